// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and helpers for the load/store writeback unit
package lsu_pkg;

  // Op type encodings (2'b11 is reserved and handled as ALU)
  localparam logic [1:0] TYPE_ALU   = 2'b00;
  localparam logic [1:0] TYPE_LOAD  = 2'b01;
  localparam logic [1:0] TYPE_STORE = 2'b10;

  // funct3 size/sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } lsu_size_e;

  // Access size from funct3; unused encodings fall back to word
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    lsu_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] ofs);
    logic mis;
    case (f3_size(f3))
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = ofs[0];
      default: mis = (ofs != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_ldext.sv
// rtl/lsu_ldext.sv - load lane select and sign/zero extension
module lsu_ldext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  ofs,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] sh;

  // Shift the addressed lane down to bit 0, then extend according to funct3
  always_comb begin
    sh = rdata >> {ofs, 3'b000};
    case (funct3)
      F3_B:    data = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   data = {24'd0, sh[7:0]};
      F3_H:    data = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   data = {16'd0, sh[15:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// rtl/lsu_wb.sv - load/store unit and single register-file writeback source
module lsu_wb
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          exu_lsu_vld,
  output logic          lsu_exu_rdy,
  input  logic [1:0]    exu_lsu_type,
  input  logic [2:0]    exu_lsu_funct3,
  input  logic [AW-1:0] exu_lsu_addr,
  input  logic [DW-1:0] exu_lsu_wdata,
  input  logic [DW-1:0] exu_lsu_alu_res,
  input  logic [4:0]    exu_lsu_rd,
  output logic          lsu_mem_req,
  output logic          lsu_mem_we,
  output logic [AW-1:0] lsu_mem_addr,
  output logic [DW-1:0] lsu_mem_wdata,
  output logic [3:0]    lsu_mem_be,
  input  logic          mem_lsu_gnt,
  input  logic          mem_lsu_rvld,
  input  logic [DW-1:0] mem_lsu_rdata,
  output logic          lsu_rf_wb_vld,
  output logic [4:0]    lsu_rf_wb_addr,
  output logic [DW-1:0] lsu_rf_wb_data,
  output logic          lsu_misalign_err
);

  lsu_state_e  state;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;
  logic [1:0]  ofs_q;
  logic        is_load_q;

  logic          is_mem;
  logic [1:0]    ofs;
  logic [3:0]    st_be;
  logic [DW-1:0] st_wdata;
  logic [DW-1:0] ld_data;

  assign lsu_exu_rdy = (state == ST_IDLE);
  assign ofs         = exu_lsu_addr[1:0];
  assign is_mem      = (exu_lsu_type == TYPE_LOAD) || (exu_lsu_type == TYPE_STORE);

  // Replicate store data across lanes and pick byte enables from size and offset
  always_comb begin
    st_be    = 4'hF;
    st_wdata = exu_lsu_wdata;
    case (f3_size(exu_lsu_funct3))
      SZ_B: begin
        st_be    = 4'b0001 << ofs;
        st_wdata = {4{exu_lsu_wdata[7:0]}};
      end
      SZ_H: begin
        st_be    = 4'b0011 << ofs;
        st_wdata = {2{exu_lsu_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = exu_lsu_wdata;
      end
    endcase
  end

  lsu_ldext u_ldext (
    .funct3 (f3_q),
    .ofs    (ofs_q),
    .rdata  (mem_lsu_rdata),
    .data   (ld_data)
  );

  // Op FSM: accept in IDLE, hold the memory request until grant, write back ALU and load results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      rd_q             <= '0;
      f3_q             <= '0;
      ofs_q            <= '0;
      is_load_q        <= 1'b0;
      lsu_mem_req      <= 1'b0;
      lsu_mem_we       <= 1'b0;
      lsu_mem_addr     <= '0;
      lsu_mem_wdata    <= '0;
      lsu_mem_be       <= '0;
      lsu_rf_wb_vld    <= 1'b0;
      lsu_rf_wb_addr   <= '0;
      lsu_rf_wb_data   <= '0;
      lsu_misalign_err <= 1'b0;
    end else begin
      lsu_rf_wb_vld    <= 1'b0;
      lsu_misalign_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (exu_lsu_vld) begin
            if (!is_mem) begin
              // x0 is never written, but the op still completes
              lsu_rf_wb_vld  <= (exu_lsu_rd != 5'd0);
              lsu_rf_wb_addr <= exu_lsu_rd;
              lsu_rf_wb_data <= exu_lsu_alu_res;
            end else if (is_misaligned(exu_lsu_funct3, ofs)) begin
              lsu_misalign_err <= 1'b1;
            end else begin
              rd_q          <= exu_lsu_rd;
              f3_q          <= exu_lsu_funct3;
              ofs_q         <= ofs;
              is_load_q     <= (exu_lsu_type == TYPE_LOAD);
              lsu_mem_req   <= 1'b1;
              lsu_mem_we    <= (exu_lsu_type == TYPE_STORE);
              lsu_mem_addr  <= {exu_lsu_addr[AW-1:2], 2'b00};
              lsu_mem_wdata <= st_wdata;
              lsu_mem_be    <= st_be;
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_lsu_gnt) begin
            lsu_mem_req <= 1'b0;
            state       <= is_load_q ? ST_RESP : ST_IDLE;
          end
        end
        ST_RESP: begin
          if (mem_lsu_rvld) begin
            lsu_rf_wb_vld  <= (rd_q != 5'd0);
            lsu_rf_wb_addr <= rd_q;
            lsu_rf_wb_data <= ld_data;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb.sv
// tb/tb_lsu_wb.sv - self-checking bench for lsu_wb with a writeback scoreboard
module tb_lsu_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_lsu_vld;
  logic        lsu_exu_rdy;
  logic [1:0]  exu_lsu_type;
  logic [2:0]  exu_lsu_funct3;
  logic [31:0] exu_lsu_addr;
  logic [31:0] exu_lsu_wdata;
  logic [31:0] exu_lsu_alu_res;
  logic [4:0]  exu_lsu_rd;
  logic        lsu_mem_req;
  logic        lsu_mem_we;
  logic [31:0] lsu_mem_addr;
  logic [31:0] lsu_mem_wdata;
  logic [3:0]  lsu_mem_be;
  logic        mem_lsu_gnt;
  logic        mem_lsu_rvld;
  logic [31:0] mem_lsu_rdata;
  logic        lsu_rf_wb_vld;
  logic [4:0]  lsu_rf_wb_addr;
  logic [31:0] lsu_rf_wb_data;
  logic        lsu_misalign_err;

  lsu_wb #(.AW(32), .DW(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .exu_lsu_vld      (exu_lsu_vld),
    .lsu_exu_rdy      (lsu_exu_rdy),
    .exu_lsu_type     (exu_lsu_type),
    .exu_lsu_funct3   (exu_lsu_funct3),
    .exu_lsu_addr     (exu_lsu_addr),
    .exu_lsu_wdata    (exu_lsu_wdata),
    .exu_lsu_alu_res  (exu_lsu_alu_res),
    .exu_lsu_rd       (exu_lsu_rd),
    .lsu_mem_req      (lsu_mem_req),
    .lsu_mem_we       (lsu_mem_we),
    .lsu_mem_addr     (lsu_mem_addr),
    .lsu_mem_wdata    (lsu_mem_wdata),
    .lsu_mem_be       (lsu_mem_be),
    .mem_lsu_gnt      (mem_lsu_gnt),
    .mem_lsu_rvld     (mem_lsu_rvld),
    .mem_lsu_rdata    (mem_lsu_rdata),
    .lsu_rf_wb_vld    (lsu_rf_wb_vld),
    .lsu_rf_wb_addr   (lsu_rf_wb_addr),
    .lsu_rf_wb_data   (lsu_rf_wb_data),
    .lsu_misalign_err (lsu_misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Every writeback pulse must match the oldest expected entry
  always @(negedge clk) begin : wb_mon
    wb_t e;
    if (!rst && lsu_rf_wb_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("wb_addr", 32'(lsu_rf_wb_addr), 32'(e.addr));
        check("wb_data", lsu_rf_wb_data, e.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic issue(input logic [1:0] t, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] alu, input logic [4:0] rd);
    check("rdy_at_issue", 32'(lsu_exu_rdy), 32'd1);
    exu_lsu_vld     = 1'b1;
    exu_lsu_type    = t;
    exu_lsu_funct3  = f3;
    exu_lsu_addr    = a;
    exu_lsu_wdata   = wd;
    exu_lsu_alu_res = alu;
    exu_lsu_rd      = rd;
    @(negedge clk);
    exu_lsu_vld     = 1'b0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] res);
    if (rd != 5'd0) sb_q.push_back('{addr: rd, data: res});
    issue(2'b00, 3'b000, 32'h0, 32'h0, res, rd);
  endtask

  task automatic load_op(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                         input logic [31:0] rdata, input int stall, input logic [31:0] exp);
    int reqs = 0;
    if (rd != 5'd0) sb_q.push_back('{addr: rd, data: exp});
    issue(2'b01, f3, a, 32'h0, 32'h0, rd);
    for (int i = 0; i <= stall; i++) begin
      if (lsu_mem_req === 1'b1) reqs++;
      check("ld_addr", lsu_mem_addr, {a[31:2], 2'b00});
      check("ld_we", 32'(lsu_mem_we), 32'd0);
      check("ld_rdy_busy", 32'(lsu_exu_rdy), 32'd0);
      if (i == stall) mem_lsu_gnt = 1'b1;
      @(negedge clk);
    end
    mem_lsu_gnt = 1'b0;
    check("ld_req_cycles", 32'(reqs), 32'(stall + 1));
    check("ld_req_drop", 32'(lsu_mem_req), 32'd0);
    check("ld_no_wb_in_resp", 32'(lsu_rf_wb_vld), 32'd0);
    @(negedge clk);
    mem_lsu_rvld  = 1'b1;
    mem_lsu_rdata = rdata;
    @(negedge clk);
    mem_lsu_rvld  = 1'b0;
    mem_lsu_rdata = 32'h0;
    check("ld_rdy_after", 32'(lsu_exu_rdy), 32'd1);
  endtask

  task automatic store_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    issue(2'b10, f3, a, wd, 32'h0, 5'd1);
    check("st_req", 32'(lsu_mem_req), 32'd1);
    check("st_we", 32'(lsu_mem_we), 32'd1);
    check("st_addr", lsu_mem_addr, {a[31:2], 2'b00});
    check("st_be", 32'(lsu_mem_be), 32'(exp_be));
    check("st_wdata", lsu_mem_wdata, exp_wd);
    mem_lsu_gnt = 1'b1;
    @(negedge clk);
    mem_lsu_gnt = 1'b0;
    check("st_req_drop", 32'(lsu_mem_req), 32'd0);
    check("st_rdy_after_gnt", 32'(lsu_exu_rdy), 32'd1);
  endtask

  task automatic misalign_op(input logic [1:0] t, input logic [2:0] f3, input logic [31:0] a);
    issue(t, f3, a, 32'h1234_5678, 32'h0, 5'd3);
    check("mis_pulse", 32'(lsu_misalign_err), 32'd1);
    check("mis_no_req", 32'(lsu_mem_req), 32'd0);
    check("mis_rdy", 32'(lsu_exu_rdy), 32'd1);
    @(negedge clk);
    check("mis_pulse_end", 32'(lsu_misalign_err), 32'd0);
    check("mis_no_req_late", 32'(lsu_mem_req), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, 32'(lsu_exu_rdy), 32'd1);
    check({tag, "_req"}, 32'(lsu_mem_req), 32'd0);
    check({tag, "_we"}, 32'(lsu_mem_we), 32'd0);
    check({tag, "_maddr"}, lsu_mem_addr, 32'd0);
    check({tag, "_be"}, 32'(lsu_mem_be), 32'd0);
    check({tag, "_wbvld"}, 32'(lsu_rf_wb_vld), 32'd0);
    check({tag, "_wbdata"}, lsu_rf_wb_data, 32'd0);
    check({tag, "_mis"}, 32'(lsu_misalign_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    exu_lsu_vld     = 1'b0;
    exu_lsu_type    = 2'b00;
    exu_lsu_funct3  = 3'b000;
    exu_lsu_addr    = 32'h0;
    exu_lsu_wdata   = 32'h0;
    exu_lsu_alu_res = 32'h0;
    exu_lsu_rd      = 5'd0;
    mem_lsu_gnt     = 1'b0;
    mem_lsu_rvld    = 1'b0;
    mem_lsu_rdata   = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // ALU ops back to back; rd=0 must not write
    alu_op(5'd5, 32'h1234_5678);
    alu_op(5'd0, 32'hDEAD_0000);
    alu_op(5'd31, 32'hA5A5_0F0F);
    @(negedge clk);

    // Loads across sizes, offsets and sign
    load_op(3'b000, 32'h0000_0103, 5'd3, 32'h80AA_BBCC, 2, 32'hFFFF_FF80);
    load_op(3'b100, 32'h0000_0103, 5'd4, 32'h80AA_BBCC, 0, 32'h0000_0080);
    load_op(3'b001, 32'h0000_0102, 5'd6, 32'h7FFF_0000, 1, 32'h0000_7FFF);
    load_op(3'b010, 32'h0000_0100, 5'd7, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
    load_op(3'b101, 32'h0000_0102, 5'd8, 32'h8001_1234, 0, 32'h0000_8001);
    load_op(3'b001, 32'h0000_0100, 5'd9, 32'h1234_F00D, 0, 32'hFFFF_F00D);
    load_op(3'b000, 32'h0000_0101, 5'd10, 32'h0000_7F00, 0, 32'h0000_007F);
    load_op(3'b111, 32'h0000_0104, 5'd11, 32'h0BAD_CAFE, 0, 32'h0BAD_CAFE);
    load_op(3'b010, 32'h0000_0104, 5'd0, 32'h1111_2222, 1, 32'h0);

    // Stores: lane alignment, no writeback
    store_op(3'b000, 32'h0000_0101, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
    store_op(3'b001, 32'h0000_0102, 32'h9999_BEEF, 4'b1100, 32'hBEEF_BEEF);
    store_op(3'b010, 32'h0000_0108, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    store_op(3'b000, 32'h0000_0003, 32'h0000_003C, 4'b1000, 32'h3C3C_3C3C);

    // Misaligned accesses
    misalign_op(2'b10, 3'b010, 32'h0000_0102);
    misalign_op(2'b01, 3'b001, 32'h0000_0101);

    // Stray memory handshakes while idle are ignored
    mem_lsu_gnt   = 1'b1;
    mem_lsu_rvld  = 1'b1;
    mem_lsu_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_lsu_gnt   = 1'b0;
    mem_lsu_rvld  = 1'b0;
    @(negedge clk);
    check("stray_no_req", 32'(lsu_mem_req), 32'd0);
    check("stray_rdy", 32'(lsu_exu_rdy), 32'd1);

    // Reset while waiting for load data; late response must be dropped
    issue(2'b01, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 5'd12);
    mem_lsu_gnt = 1'b1;
    @(negedge clk);
    mem_lsu_gnt = 1'b0;
    check("rst_in_resp", 32'(lsu_exu_rdy), 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_lsu_rvld  = 1'b1;
    mem_lsu_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_lsu_rvld  = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");
    alu_op(5'd7, 32'h0F0F_F0F0);
    @(negedge clk);
    @(negedge clk);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
- Load/store and writeback unit; it is the write side of the register file.
- Accepts one op at a time from the EXU over a valid/ready handshake and runs the data-memory request/response for loads and stores.
- It is the only block that drives the register file write port: lsu_rf_wb_vld, lsu_rf_wb_addr and lsu_rf_wb_data.
- ALU results pass through it so that register writes come from a single source.

Parameters:
- AW, 32, data memory address width
- DW, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- exu_lsu_vld  in  1  op valid
- lsu_exu_rdy  out  1  unit can accept an op
- exu_lsu_type  in  2  00 ALU, 01 LOAD, 10 STORE, 11 reserved (treated as ALU)
- exu_lsu_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- exu_lsu_addr  in  AW  effective address
- exu_lsu_wdata  in  DW  store data
- exu_lsu_alu_res  in  DW  ALU result
- exu_lsu_rd  in  5  destination register
- lsu_mem_req  out  1  memory request
- lsu_mem_we  out  1  1 = store
- lsu_mem_addr  out  AW  word-aligned address (addr[1:0]=0)
- lsu_mem_wdata  out  DW  lane-aligned store data
- lsu_mem_be  out  4  byte enables
- mem_lsu_gnt  in  1  request accepted
- mem_lsu_rvld  in  1  load data valid
- mem_lsu_rdata  in  DW  load data word
- lsu_rf_wb_vld  out  1  register file write enable
- lsu_rf_wb_addr  out  5  register file write address
- lsu_rf_wb_data  out  DW  register file write data
- lsu_misalign_err  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE. All outputs are 0 except lsu_exu_rdy, which is 1.
- FSM states: IDLE, REQ, RESP.
- lsu_exu_rdy = (state==IDLE). An op is accepted on a cycle where vld & rdy.
- ALU op: accepted in IDLE. The next cycle drives lsu_rf_wb_vld=1 with the registered rd and alu_res; state stays IDLE. Latency 1, back-to-back ALU ops allowed.
- Misalignment: H with addr[0]=1, or W with addr[1:0]!=0.
  - Pulse lsu_misalign_err the cycle after accept.
  - No memory request and no writeback; stay in IDLE.
- LOAD/STORE aligned, IDLE→REQ:
  - Latch rd, funct3, addr[1:0] and type.
  - lsu_mem_req=1 from the next cycle and held with stable address, data and be until mem_lsu_gnt.
- REQ on gnt:
  - Store → IDLE.
  - Load → RESP.
  - req drops the cycle after gnt.
- RESP on mem_lsu_rvld: extract and extend the data, then →IDLE. The next cycle drives lsu_rf_wb_vld=1.
- Load-to-writeback latency: the wb pulse is the cycle after rvld. rvld in the same cycle as gnt is illegal; the memory returns data at least 1 cycle after gnt.
- Load extraction: sh = rdata >> (8*addr[1:0]).
  - B: sign-extend sh[7:0].
  - BU: zero-extend sh[7:0].
  - H: sign-extend sh[15:0].
  - HU: zero-extend sh[15:0].
  - W: sh unchanged.
- Store lane alignment:
  - B: be = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: be = 4'b0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - W: be = 4'hF.
- rd==0: lsu_rf_wb_vld is suppressed for both ALU and load. The memory access still occurs.
- lsu_rf_wb_vld is a single-cycle pulse per op and is never asserted in REQ.
- Unused funct3 encodings (011, 110, 111) are treated as W.
- mem_lsu_rvld or mem_lsu_gnt arriving in IDLE is ignored.
- Reset asserted mid-op: the op is aborted and no writeback occurs. A late response after reset is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - type encodings: TYPE_ALU, TYPE_LOAD, TYPE_STORE
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - FSM state encodings
- One natural sub-module: lsu_ldext, combinational load lane-select and sign/zero extension.
- The FSM, store alignment and writeback register live in lsu_wb.

Test Plan:
- ALU op, rd=5, alu_res=0x1234_5678 → next cycle wb_vld=1, addr=5, data=0x1234_5678. Then ALU op with rd=0 → wb_vld stays 0.
- LB at addr 0x103, rdata=0x80AA_BBCC, gnt after 2 stall cycles:
  - req is held 3 cycles with mem_addr=0x100, we=0.
  - wb_data=0xFFFF_FF80 the cycle after rvld.
  - LBU of the same access → 0x0000_0080.
- LH at 0x102, rdata=0x7FFF_0000 → wb_data=0x0000_7FFF. LW at 0x100 → wb_data equals rdata.
- SB at 0x101, wdata=0xXXXX_XXA5 → be=4'b0010, mem_wdata=0xA5A5_A5A5, we=1. No wb pulse. rdy returns 1 the cycle after gnt.
- SW at 0x102 → lsu_misalign_err pulses once, no req, rdy stays 1. LH at 0x101 → same.
- LW issued, rst pulsed while in RESP, then rvld arrives → no wb_vld, outputs are at reset values, and a subsequent ALU op completes normally.
